// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM encoding, word width and
// parameter defaults.
package mem_arb_pkg;

  localparam int unsigned WordW         = 16;
  localparam int unsigned DefStarveMax  = 4;
  localparam int unsigned DefTimeout    = 64;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StBusyI = 3'd1,
    StBusyD = 3'd2,
    StRespI = 3'd3,
    StRespD = 3'd4
  } arb_state_e;

endpackage

// File: rtl/arb_timer.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
// Used both as the data-grant run counter and as the memory-wait timer.
module arb_timer #(
  parameter int unsigned Width = 4,
  parameter int unsigned Max   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != Width'(Max))) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter with anti-starvation and
// fetch cancel. Optional wait timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DefStarveMax,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic             i_cancel,
  input  logic [WordW-1:0] i_addr,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [WordW-1:0] d_addr,
  input  logic [WordW-1:0] d_wdata,
  output logic             i_done,
  output logic             d_done,
  output logic [WordW-1:0] i_rdata,
  output logic [WordW-1:0] d_rdata,
  output logic             i_stall,
  output logic             d_stall,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [WordW-1:0] mem_addr,
  output logic [WordW-1:0] mem_wdata,
  input  logic [WordW-1:0] mem_rdata,
  input  logic             mem_done,
  output logic             err
);

  localparam int unsigned RunW = $clog2(STARVE_MAX + 1);

  arb_state_e      state_q, state_d;
  logic            drop_q, drop_d;
  logic            grant_i, grant_d;
  logic            starved;
  logic            timeout;
  logic [RunW-1:0] run_cnt;

  arb_timer #(
    .Width (RunW),
    .Max   (STARVE_MAX)
  ) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (grant_i || (grant_d && !i_req)),
    .en    (grant_d && i_req),
    .count (run_cnt)
  );

  assign starved = (run_cnt == RunW'(STARVE_MAX));

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (d_req && !(i_req && starved)) begin
          grant_d = 1'b1;
          state_d = StBusyD;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_d = StBusyI;
        end
      end
      StBusyI: begin
        if (i_cancel) drop_d = 1'b1;
        if (mem_done || timeout) begin
          // A cancel seen at any point in BUSY_I discards the response entirely.
          state_d = (drop_q || i_cancel) ? StIdle : StRespI;
          drop_d  = 1'b0;
        end
      end
      StBusyD: begin
        if (mem_done || timeout) state_d = StRespD;
      end
      StRespI, StRespD: state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      drop_q    <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      mem_en  <= grant_i || grant_d;
      if (grant_d) begin
        mem_addr  <= d_addr;
        mem_wr    <= d_wr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_addr  <= i_addr;
        mem_wr    <= 1'b0;
        mem_wdata <= '0;
      end
      if ((state_q == StBusyI) && (state_d == StRespI)) begin
        i_rdata <= mem_done ? mem_rdata : '0;
      end
      // Completed writes leave d_rdata alone; a timed-out access returns zero.
      if ((state_q == StBusyD) && (state_d == StRespD) && (!mem_wr || !mem_done)) begin
        d_rdata <= mem_done ? mem_rdata : '0;
      end
    end
  end

  assign i_done  = (state_q == StRespI) && !i_cancel;
  assign d_done  = (state_q == StRespD);
  assign i_stall = i_req && !i_done && !rst;
  assign d_stall = d_req && !d_done && !rst;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  logic              busy;
  logic [TimerW-1:0] tmr_cnt;

  assign busy = (state_q == StBusyI) || (state_q == StBusyD);

  arb_timer #(
    .Width (TimerW),
    .Max   (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (!busy),
    .en    (busy),
    .count (tmr_cnt)
  );

  assign timeout = busy && !mem_done && (tmr_cnt == TimerW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: fetch/data arbitration, starvation limit, cancel,
// reset and (with MEM_ARB_TIMEOUT_EN) the wait timeout.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, i_cancel = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_done, d_done, i_stall, d_stall, mem_en, mem_wr, err;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        mem_done;
  logic [15:0] mem_rdata;

  // Memory stand-in: either zero-wait auto-response or manually driven.
  logic        auto_mode = 1'b0;
  logic [15:0] auto_rdata = '0;
  logic        man_done = 1'b0;
  logic [15:0] man_rdata = '0;
  assign mem_done  = auto_mode ? mem_en : man_done;
  assign mem_rdata = auto_mode ? auto_rdata : man_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .STARVE_MAX (4),
    .TIMEOUT    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_cancel  (i_cancel),
    .i_addr    (i_addr),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .i_done    (i_done),
    .d_done    (d_done),
    .i_rdata   (i_rdata),
    .d_rdata   (d_rdata),
    .i_stall   (i_stall),
    .d_stall   (d_stall),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .err       (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #1;
    vectors++;
    if ({i_done, d_done, i_stall, d_stall, mem_en, mem_wr, err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {i_done, d_done, i_stall, d_stall, mem_en, mem_wr, err});
    end
    vectors++;
    if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_words got=%h exp=0", {i_rdata, d_rdata, mem_addr, mem_wdata});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch_read();
    auto_mode = 1'b1; auto_rdata = 16'hBEEF;
    i_req = 1'b1; i_addr = 16'h0040;
    #1;
    vectors++;
    if (mem_en !== 1'b0 || i_stall !== 1'b1) begin
      miscompares++; $display("FAIL fetch_c0 mem_en=%b i_stall=%b exp 0/1", mem_en, i_stall);
    end
    step();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0040 || mem_wr !== 1'b0 || i_done !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_c1 mem_en=%b addr=%h wr=%b i_done=%b exp 1/0040/0/0",
               mem_en, mem_addr, mem_wr, i_done);
    end
    step();
    vectors++;
    if (i_done !== 1'b1 || i_rdata !== 16'hBEEF || i_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_c2 i_done=%b i_rdata=%h i_stall=%b exp 1/beef/0",
               i_done, i_rdata, i_stall);
    end
    i_req = 1'b0;
    step();
    vectors++;
    if (i_done !== 1'b0 || mem_en !== 1'b0) begin
      miscompares++; $display("FAIL fetch_c3 i_done=%b mem_en=%b exp 0/0", i_done, mem_en);
    end
  endtask

  task automatic test_both_requesters();
    auto_mode = 1'b1; auto_rdata = 16'h5555;
    i_req = 1'b1; i_addr = 16'h0200;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
    step();
    vectors++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL both_dgrant en=%b wr=%b addr=%h wdata=%h exp 1/1/0100/1234",
               mem_en, mem_wr, mem_addr, mem_wdata);
    end
    step();
    vectors++;
    if (d_done !== 1'b1 || i_done !== 1'b0 || d_rdata !== 16'h0000) begin
      miscompares++;
      $display("FAIL both_ddone d_done=%b i_done=%b d_rdata=%h exp 1/0/0000",
               d_done, i_done, d_rdata);
    end
    d_req = 1'b0; d_wr = 1'b0;
    step();
    vectors++;
    if (mem_en !== 1'b0 || d_done !== 1'b0 || i_done !== 1'b0) begin
      miscompares++;
      $display("FAIL both_idle en=%b d_done=%b i_done=%b exp 0/0/0", mem_en, d_done, i_done);
    end
    step();
    vectors++;
    if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0200 || mem_wdata !== 16'h0000) begin
      miscompares++;
      $display("FAIL both_igrant en=%b wr=%b addr=%h wdata=%h exp 1/0/0200/0000",
               mem_en, mem_wr, mem_addr, mem_wdata);
    end
    step();
    vectors++;
    if (i_done !== 1'b1 || i_rdata !== 16'h5555) begin
      miscompares++; $display("FAIL both_idone i_done=%b i_rdata=%h exp 1/5555", i_done, i_rdata);
    end
    i_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic is_data [16];
    logic exp_data [10];
    int   n = 0;
    exp_data = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    auto_mode = 1'b1; auto_rdata = 16'h5555;
    i_req = 1'b1; i_addr = 16'hAAAA;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'hDDDD;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (mem_en === 1'b1 && n < 16) begin
        is_data[n] = (mem_addr == 16'hDDDD);
        n++;
      end
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    vectors++;
    if (n !== 10) begin
      miscompares++; $display("FAIL starve_count got=%0d exp=10", n);
    end
    for (int k = 0; k < 10; k++) begin
      if (k < n) begin
        vectors++;
        if (is_data[k] !== exp_data[k]) begin
          miscompares++;
          $display("FAIL starve_grant%0d got_data=%b exp_data=%b", k, is_data[k], exp_data[k]);
        end
      end
    end
    step();
  endtask

  task automatic test_cancel_busy();
    auto_mode = 1'b0; man_done = 1'b0;
    i_req = 1'b1; i_addr = 16'h0300;
    step();
    i_cancel = 1'b1;
    #1;
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0300) begin
      miscompares++; $display("FAIL cancel_grant en=%b addr=%h exp 1/0300", mem_en, mem_addr);
    end
    step();
    i_cancel = 1'b0; i_req = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
    step();
    step();
    man_done = 1'b1; man_rdata = 16'hDEAD;
    #1;
    vectors++;
    if (i_done !== 1'b0 || mem_en !== 1'b0 || d_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL cancel_wait i_done=%b en=%b d_stall=%b exp 0/0/1", i_done, mem_en, d_stall);
    end
    step();
    man_done = 1'b0;
    #1;
    vectors++;
    if (i_done !== 1'b0 || mem_en !== 1'b0 || i_rdata !== 16'h5555) begin
      miscompares++;
      $display("FAIL cancel_idle i_done=%b en=%b i_rdata=%h exp 0/0/5555", i_done, mem_en, i_rdata);
    end
    step();
    man_done = 1'b1; man_rdata = 16'h0707;
    #1;
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0400 || mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_dgrant en=%b addr=%h wr=%b exp 1/0400/0", mem_en, mem_addr, mem_wr);
    end
    step();
    man_done = 1'b0;
    #1;
    vectors++;
    if (d_done !== 1'b1 || d_rdata !== 16'h0707 || i_done !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_ddone d_done=%b d_rdata=%h i_done=%b exp 1/0707/0",
               d_done, d_rdata, i_done);
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic test_cancel_resp();
    auto_mode = 1'b1; auto_rdata = 16'h6666;
    i_req = 1'b1; i_addr = 16'h0600;
    step();
    step();
    i_cancel = 1'b1;
    #1;
    vectors++;
    if (i_done !== 1'b0 || i_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL cancel_resp i_done=%b i_stall=%b exp 0/1", i_done, i_stall);
    end
    i_req = 1'b0;
    step();
    i_cancel = 1'b0;
    #1;
    vectors++;
    if (i_done !== 1'b0 || mem_en !== 1'b0) begin
      miscompares++; $display("FAIL cancel_resp_after i_done=%b en=%b exp 0/0", i_done, mem_en);
    end
    auto_mode = 1'b0;
    step();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    man_done = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500;
    for (int k = 1; k <= 8; k++) begin
      step();
      vectors++;
      if (d_done !== 1'b0 || err !== 1'b0) begin
        miscompares++; $display("FAIL tmo_busy%0d d_done=%b err=%b exp 0/0", k, d_done, err);
      end
    end
    step();
    vectors++;
    if (d_done !== 1'b1 || err !== 1'b1 || d_rdata !== 16'h0000) begin
      miscompares++;
      $display("FAIL tmo_resp d_done=%b err=%b d_rdata=%h exp 1/1/0000", d_done, err, d_rdata);
    end
    d_req = 1'b0;
    step();
    step();
    vectors++;
    if (err !== 1'b1 || d_done !== 1'b0) begin
      miscompares++; $display("FAIL tmo_sticky err=%b d_done=%b exp 1/0", err, d_done);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL tmo_rst err=%b exp 0", err);
    end
    rst = 1'b0;
    step();
  endtask
`else
  task automatic test_no_timeout();
    man_done = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500;
    for (int k = 1; k <= 20; k++) begin
      step();
      vectors++;
      if (d_done !== 1'b0 || err !== 1'b0 || d_stall !== 1'b1) begin
        miscompares++;
        $display("FAIL notmo_busy%0d d_done=%b err=%b d_stall=%b exp 0/0/1",
                 k, d_done, err, d_stall);
      end
    end
    d_req = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
  endtask
`endif

  task automatic test_reset_mid();
    auto_mode = 1'b0; man_done = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0800;
    step();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0800) begin
      miscompares++; $display("FAIL rmid_grant en=%b addr=%h exp 1/0800", mem_en, mem_addr);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (mem_en !== 1'b0 || mem_addr !== 16'h0 || d_stall !== 1'b0 || i_rdata !== 16'h0) begin
      miscompares++;
      $display("FAIL rmid_async en=%b addr=%h d_stall=%b i_rdata=%h exp 0/0000/0/0000",
               mem_en, mem_addr, d_stall, i_rdata);
    end
    d_req = 1'b0;
    step();
    rst = 1'b0;
    man_done = 1'b1; man_rdata = 16'h9999;
    step();
    man_done = 1'b0;
    #1;
    vectors++;
    if (d_done !== 1'b0 || i_done !== 1'b0 || mem_en !== 1'b0 || d_rdata !== 16'h0) begin
      miscompares++;
      $display("FAIL rmid_stray d_done=%b i_done=%b en=%b d_rdata=%h exp 0/0/0/0000",
               d_done, i_done, mem_en, d_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_both_requesters();
    test_starvation();
    test_cancel_busy();
    test_cancel_resp();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
